// File: rtl/st7735_pkg.sv
// Shared opcodes, register reset values and decoder state encoding for the
// ST7735 command-stream decoder.
package st7735_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_NORON   = 8'h13;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [7:0] COLMOD_RST  = 8'h06;
  localparam logic [7:0] MADCTL_RST  = 8'h00;
  localparam logic [2:0] COLMOD_565  = 3'b101;

  typedef enum logic [2:0] {
    S_CMD,
    S_ARG,
    S_IGNORE,
    S_PIX_HI,
    S_PIX_LO
  } dec_state_e;

endpackage

// File: rtl/st7735_cmd_decoder_spi_rx.sv
// SPI byte receiver: synchronizes SCK/MOSI/DC/CS_n into clk, shifts MSB first
// on SCK rising edges and strobes each complete byte with its DC level.
module st7735_cmd_decoder_spi_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  input  logic       cs_n_i,
  output logic       byte_stb_o,
  output logic [7:0] byte_o,
  output logic       is_data_o
);
  // Bit order in the sync vectors: {cs_n, dc, mosi, sck}
  logic [3:0] meta_q, sync_q;
  logic       sck_prev_q;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       is_data_q;
  logic       stb_q;
  logic       sck_rise;

  assign sck_rise = sync_q[0] & ~sck_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 4'b1000;
      sync_q     <= 4'b1000;
      sck_prev_q <= 1'b0;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      byte_q     <= 8'd0;
      is_data_q  <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      meta_q     <= {cs_n_i, dc_i, mosi_i, sck_i};
      sync_q     <= meta_q;
      sck_prev_q <= sync_q[0];
      stb_q      <= 1'b0;
      if (sync_q[3]) begin
        cnt_q <= 3'd0;
      end else if (sck_rise) begin
        shift_q <= {shift_q[5:0], sync_q[1]};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q    <= {shift_q, sync_q[1]};
          is_data_q <= sync_q[2];
          stb_q     <= 1'b1;
        end
      end
    end
  end

  assign byte_stb_o = stb_q;
  assign byte_o     = byte_q;
  assign is_data_o  = is_data_q;

endmodule

// File: rtl/st7735_cmd_decoder.sv
// ST7735 panel model / bus monitor: decodes commands, tracks panel registers and
// emits RGB565 pixel strobes during RAMWR. Optional ST7735_DEC_MADCTL_EN remaps x/y.
module st7735_cmd_decoder
  import st7735_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  input  logic        spi_cs_n,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        cmd_err,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sleep_out,
  output logic        disp_on,
  output logic [7:0]  colmod,
  output logic [7:0]  madctl
);
  localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);
  localparam logic [8:0] W9    = 9'(WIDTH);
  localparam logic [8:0] H9    = 9'(HEIGHT);

  logic       rx_stb, rx_is_data;
  logic [7:0] rx_byte;

  st7735_cmd_decoder_spi_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (spi_sck),
    .mosi_i     (spi_mosi),
    .dc_i       (spi_dc),
    .cs_n_i     (spi_cs_n),
    .byte_stb_o (rx_stb),
    .byte_o     (rx_byte),
    .is_data_o  (rx_is_data)
  );

  dec_state_e  state_q, state_d;
  logic [7:0]  pend_q, pend_d, arg1_q, arg1_d, hi_q, hi_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  cx_q, cx_d, cy_q, cy_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d, colmod_q, colmod_d, madctl_q, madctl_d;
  logic        sleep_q, sleep_d, disp_q, disp_d;
  logic        cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d;
  logic        pv_q, pv_d;
  logic [7:0]  px_q, px_d, py_q, py_d;
  logic [15:0] pd_q, pd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CMD;
      pend_q      <= CMD_NOP;
      arg1_q      <= 8'd0;
      hi_q        <= 8'd0;
      idx_q       <= 2'd0;
      xs_q        <= 8'd0;
      xe_q        <= X_MAX;
      ys_q        <= 8'd0;
      ye_q        <= Y_MAX;
      cx_q        <= 8'd0;
      cy_q        <= 8'd0;
      cmd_byte_q  <= 8'd0;
      colmod_q    <= COLMOD_RST;
      madctl_q    <= MADCTL_RST;
      sleep_q     <= 1'b0;
      disp_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      pv_q        <= 1'b0;
      px_q        <= 8'd0;
      py_q        <= 8'd0;
      pd_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      arg1_q      <= arg1_d;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      cmd_byte_q  <= cmd_byte_d;
      colmod_q    <= colmod_d;
      madctl_q    <= madctl_d;
      sleep_q     <= sleep_d;
      disp_q      <= disp_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      pv_q        <= pv_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pd_q        <= pd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    arg1_d      = arg1_q;
    hi_d        = hi_q;
    idx_d       = idx_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    cmd_byte_d  = cmd_byte_q;
    colmod_d    = colmod_q;
    madctl_d    = madctl_q;
    sleep_d     = sleep_q;
    disp_d      = disp_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    pv_d        = 1'b0;
    px_d        = px_q;
    py_d        = py_q;
    pd_d        = pd_q;

    if (rx_stb && !rx_is_data) begin
      // Any command aborts pending arguments or a half-received pixel
      state_d     = S_CMD;
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      case (rx_byte)
        CMD_NOP, CMD_NORON: ;
        CMD_SWRESET: begin
          sleep_d  = 1'b0;
          disp_d   = 1'b0;
          colmod_d = COLMOD_RST;
          madctl_d = MADCTL_RST;
          xs_d     = 8'd0;
          xe_d     = X_MAX;
          ys_d     = 8'd0;
          ye_d     = Y_MAX;
        end
        CMD_SLPIN:   sleep_d = 1'b0;
        CMD_SLPOUT:  sleep_d = 1'b1;
        CMD_DISPOFF: disp_d  = 1'b0;
        CMD_DISPON:  disp_d  = 1'b1;
        CMD_COLMOD, CMD_MADCTL, CMD_CASET, CMD_RASET: begin
          state_d = S_ARG;
          pend_d  = rx_byte;
          idx_d   = 2'd0;
        end
        CMD_RAMWR: begin
          state_d = S_PIX_HI;
          cx_d    = xs_q;
          cy_d    = ys_q;
        end
        default: begin
          state_d     = S_IGNORE;
          cmd_valid_d = 1'b0;
          cmd_byte_d  = cmd_byte_q;
          cmd_err_d   = 1'b1;
        end
      endcase
    end else if (rx_stb) begin
      case (state_q)
        S_CMD: cmd_err_d = 1'b1;
        S_ARG: begin
          if (pend_q == CMD_COLMOD) begin
            colmod_d = rx_byte;
            state_d  = S_CMD;
          end else if (pend_q == CMD_MADCTL) begin
            madctl_d = rx_byte;
            state_d  = S_CMD;
          end else begin
            // Four-byte window argument: only low bytes (arg1, arg3) matter
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd1) arg1_d = rx_byte;
            if (idx_q == 2'd3) begin
              state_d = S_CMD;
              if (pend_q == CMD_CASET) begin
                xs_d = arg1_q;
                xe_d = rx_byte;
              end else begin
                ys_d = arg1_q;
                ye_d = rx_byte;
              end
            end
          end
        end
        S_PIX_HI: begin
          hi_d    = rx_byte;
          state_d = S_PIX_LO;
        end
        S_PIX_LO: begin
          state_d = S_PIX_HI;
          if (colmod_q[2:0] == COLMOD_565 && {1'b0, cx_q} < W9 && {1'b0, cy_q} < H9) begin
            pv_d = 1'b1;
            px_d = cx_q;
            py_d = cy_q;
            pd_d = {hi_q, rx_byte};
          end
          // 8-bit wraparound lets degenerate windows run xs..255,0..xe
          if (cx_q == xe_q) begin
            cx_d = xs_q;
            cy_d = (cy_q == ye_q) ? ys_q : cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_err   = cmd_err_q;
  assign sleep_out = sleep_q;
  assign disp_on   = disp_q;
  assign colmod    = colmod_q;
  assign madctl    = madctl_q;

`ifdef ST7735_DEC_MADCTL_EN
  logic        ov_q;
  logic [7:0]  ox_q, oy_q;
  logic [15:0] od_q;
  logic [7:0]  mx, my, rx, ry;

  always_comb begin
    mx = madctl_q[6] ? X_MAX - px_q : px_q;
    my = madctl_q[7] ? Y_MAX - py_q : py_q;
    rx = madctl_q[5] ? my : mx;
    ry = madctl_q[5] ? mx : my;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      ox_q <= 8'd0;
      oy_q <= 8'd0;
      od_q <= 16'd0;
    end else begin
      ov_q <= pv_q;
      if (pv_q) begin
        ox_q <= rx;
        oy_q <= ry;
        od_q <= pd_q;
      end
    end
  end

  assign pix_valid = ov_q;
  assign pix_x     = ox_q;
  assign pix_y     = oy_q;
  assign pix_data  = od_q;
`else
  assign pix_valid = pv_q;
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign pix_data  = pd_q;
`endif

endmodule

// File: tb/tb_st7735_cmd_decoder.sv
// Directed bench for st7735_cmd_decoder: bit-bangs SPI, logs pulses and pixels,
// compares against hand-computed expectations.
module tb_st7735_cmd_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck, spi_mosi, spi_dc, spi_cs_n;
  logic        cmd_valid, cmd_err, pix_valid, sleep_out, disp_on;
  logic [7:0]  cmd_byte, pix_x, pix_y, colmod, madctl;
  logic [15:0] pix_data;

  int n_vec = 0;
  int n_bad = 0;
  int n_cmd = 0;
  int n_err = 0;
  int rd    = 0;
  logic [31:0] px_log[$];

  always #5 clk = ~clk;

  st7735_cmd_decoder dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .spi_cs_n(spi_cs_n), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_err(cmd_err),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .sleep_out(sleep_out), .disp_on(disp_on), .colmod(colmod), .madctl(madctl)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) n_cmd++;
      if (cmd_err) n_err++;
      if (pix_valid) px_log.push_back({pix_x, pix_y, pix_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
    spi_cs_n = 1'b0;
    spi_dc   = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (4) @(posedge clk);
      spi_sck = 1'b1;
      repeat (4) @(posedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    send_bits(dc, b, 8);
    repeat (6) @(posedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(1'b0, b);
  endtask

  task automatic dat(input logic [7:0] b);
    send_byte(1'b1, b);
  endtask

  task automatic pixel(input logic [15:0] p);
    dat(p[15:8]);
    dat(p[7:0]);
  endtask

  task automatic expect_pix(input string tag, input logic [31:0] e);
    if (rd < px_log.size()) begin
      chk(tag, px_log[rd], e);
      rd++;
    end else begin
      chk({tag, " missing"}, 32'(px_log.size()), 32'(rd + 1));
    end
  endtask

  initial begin
    rst = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0; spi_cs_n = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_byte", 32'(cmd_byte), 32'h00);
    chk("rst sleep", 32'(sleep_out), 32'd0);
    chk("rst disp", 32'(disp_on), 32'd0);
    chk("rst colmod", 32'(colmod), 32'h06);
    chk("rst madctl", 32'(madctl), 32'h00);
    chk("rst pix_valid", 32'(pix_valid), 32'd0);

    // Data byte with nothing pending
    dat(8'h55);
    chk("orphan data err", 32'(n_err), 32'd1);
    chk("orphan data no cmd", 32'(n_cmd), 32'd0);

    // Init sequence
    cmd(8'h11); cmd(8'h3A); dat(8'h05); cmd(8'h29);
    chk("init cmd count", 32'(n_cmd), 32'd3);
    chk("init no err", 32'(n_err), 32'd1);
    chk("init sleep", 32'(sleep_out), 32'd1);
    chk("init colmod", 32'(colmod), 32'h05);
    chk("init disp", 32'(disp_on), 32'd1);
    chk("init cmd_byte", 32'(cmd_byte), 32'h29);

    // 2x2 window with wrap back to origin
    cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    cmd(8'h2C);
    pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F); pixel(16'hFFFF); pixel(16'h1234);
    expect_pix("win px0", {8'd2, 8'd5, 16'hF800});
    expect_pix("win px1", {8'd3, 8'd5, 16'h07E0});
    expect_pix("win px2", {8'd2, 8'd6, 16'h001F});
    expect_pix("win px3", {8'd3, 8'd6, 16'hFFFF});
    expect_pix("win px4 wrap", {8'd2, 8'd5, 16'h1234});
    chk("win pix count", 32'(px_log.size()), 32'(rd));

    // SWRESET restores colmod 0x06: pixels suppressed; then RGB565 again
    cmd(8'h01);
    chk("swreset colmod", 32'(colmod), 32'h06);
    chk("swreset sleep", 32'(sleep_out), 32'd0);
    cmd(8'h2C); pixel(16'h1111); pixel(16'h2222);
    chk("colmod6 no pix", 32'(px_log.size()), 32'(rd));
    cmd(8'h3A); dat(8'h05); cmd(8'h2C); pixel(16'hABCD);
    expect_pix("colmod5 px", {8'd0, 8'd0, 16'hABCD});

    // Unknown opcode plus trailing data
    n_err = 0;
    n_cmd = 0;
    cmd(8'hB1); dat(8'h01); dat(8'h02); dat(8'h03);
    chk("unknown err", 32'(n_err), 32'd1);
    chk("unknown no cmd", 32'(n_cmd), 32'd0);
    chk("unknown cmd_byte kept", 32'(cmd_byte), 32'h2C);

    // Partial byte discarded by CS high
    send_bits(1'b0, 8'h28, 5);
    spi_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    cmd(8'h29);
    chk("partial cmd count", 32'(n_cmd), 32'd1);
    chk("partial cmd_byte", 32'(cmd_byte), 32'h29);
    chk("partial disp", 32'(disp_on), 32'd1);

    // Degenerate window xs=254, xe=1 wraps through 0
    cmd(8'h2A); dat(8'h00); dat(8'hFE); dat(8'h00); dat(8'h01);
    cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
    cmd(8'h2C);
    pixel(16'h0001); pixel(16'h0002); pixel(16'h0003); pixel(16'h0004);
    expect_pix("degen px x0", {8'd0, 8'd0, 16'h0003});
    expect_pix("degen px x1", {8'd1, 8'd0, 16'h0004});
    chk("degen pix count", 32'(px_log.size()), 32'(rd));

    // Half pixel dropped by a new command
    cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h07);
    cmd(8'h2C); dat(8'hAA); cmd(8'h00); cmd(8'h2C); pixel(16'h1234);
    expect_pix("half drop px", {8'd5, 8'd0, 16'h1234});
    chk("half drop count", 32'(px_log.size()), 32'(rd));

    // Reset during the LO byte
    cmd(8'h2C); dat(8'h99);
    send_bits(1'b1, 8'h77, 4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst-mid no pix", 32'(px_log.size()), 32'(rd));
    chk("rst-mid cmd_byte", 32'(cmd_byte), 32'h00);
    chk("rst-mid colmod", 32'(colmod), 32'h06);
    chk("rst-mid disp", 32'(disp_on), 32'd0);
    chk("rst-mid sleep", 32'(sleep_out), 32'd0);
    chk("rst-mid pix", {pix_x, pix_y, pix_data}, 32'h0);

`ifdef ST7735_DEC_MADCTL_EN
    cmd(8'h3A); dat(8'h05); cmd(8'h36); dat(8'h40);
    chk("madctl reg", 32'(madctl), 32'h40);
    cmd(8'h2C); pixel(16'h5A5A);
    expect_pix("madctl mx px", {8'd127, 8'd0, 16'h5A5A});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/st7735_cmd_decoder.md
Name: st7735_cmd_decoder

Overview:
- Display-side responder for the ST7735 4-wire SPI command stream (SCK/MOSI/DC/CS_n).
- Deserializes the stream into bytes, interprets the init and window commands, and tracks panel state (sleep, display, COLMOD, MADCTL, CASET/RASET window).
- During RAMWR, emits one RGB565 pixel strobe with its (x,y) per pixel.
- Serves as the synthesizable panel model and bus monitor for verifying the init sequencer and framebuffer streamer.

Parameters:
- WIDTH, 128, panel columns; x coordinates are 0..WIDTH-1.
- HEIGHT, 160, panel rows; y coordinates are 0..HEIGHT-1.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst  in  1  synchronous active-high reset.
- spi_sck  in  1  SPI clock; asynchronous to clk.
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  0 = command byte, 1 = data byte.
- spi_cs_n  in  1  chip select, active low.
- cmd_valid  out  1  one-cycle pulse for each accepted command byte.
- cmd_byte  out  8  last command opcode.
- cmd_err  out  1  one-cycle pulse on unknown opcode or data byte arriving with no command pending.
- pix_valid  out  1  one-cycle pixel strobe.
- pix_x  out  8  pixel column.
- pix_y  out  8  pixel row.
- pix_data  out  16  RGB565 pixel; first byte received is [15:8].
- sleep_out  out  1  set by SLPOUT.
- disp_on  out  1  set by DISPON.
- colmod  out  8  COLMOD register.
- madctl  out  8  MADCTL register.

Behaviour:
- Input sync: 2-FF synchronizers on sck, mosi, dc, cs_n. Rising-edge detect on the synced sck.
- Shifting: shift mosi in only while synced cs_n=0. On the 8th bit, latch the byte plus dc sampled at that edge; byte_stb is registered one cycle later.
- Partial bytes: synced cs_n=1 clears the bit counter and discards any partial byte. The command FSM state is kept across CS toggles.
- Reset values: all pulses 0; cmd_byte=0x00; sleep_out=0; disp_on=0; colmod=0x06; madctl=0x00; window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; FSM in S_CMD; pix_x/pix_y/pix_data=0.
- rst mid-byte or mid-RAMWR: abandon everything immediately; no pix_valid or cmd pulse is emitted for the interrupted operation.
- FSM states: S_CMD, S_ARG, S_IGNORE, S_PIX_HI, S_PIX_LO.
  - A command byte (dc=0) is decoded from any state and aborts any argument or pixel in progress.
  - 0x00 NOP: no state change.
  - 0x01 SWRESET: restores the register defaults above.
  - 0x10 / 0x11: sleep_out <= 0 / 1.
  - 0x13: NORON; accepted, no state change.
  - 0x28 / 0x29: disp_on <= 0 / 1.
  - 0x3A (COLMOD) and 0x36 (MADCTL): S_ARG expecting 1 argument.
  - 0x2A (CASET) and 0x2B (RASET): S_ARG expecting 4 arguments.
  - 0x2C RAMWR: cursor <= (xs,ys), go to S_PIX_HI.
  - Any other opcode: cmd_err pulse, go to S_IGNORE.
  - Every accepted command pulses cmd_valid and updates cmd_byte.
- S_ARG:
  - Arguments are stored in order.
  - CASET/RASET use the low bytes of arg1 and arg3 as start and end; high bytes are ignored.
  - After the final argument the register updates in the same cycle, then return to S_CMD.
  - Extra data bytes in S_CMD pulse cmd_err and are dropped.
- S_IGNORE: data bytes are dropped silently.
- RAMWR stream:
  - Bytes pair up HI then LO.
  - On the LO byte: assert pix_valid the cycle after its byte_stb with the current cursor and {hi,lo}, then advance the cursor.
  - If x==xe: x <= xs, then y <= (y==ye) ? ys : y+1. Otherwise x <= x+1.
  - pix_valid is suppressed, but the cursor still advances, when colmod[2:0]!=3'b101 or the cursor is outside the panel (x>=WIDTH or y>=HEIGHT).
  - Degenerate windows (xs>xe, ys>ye) are kept as written. The cursor then runs from xs up to 255 and wraps through 0 to reach xe, using 8-bit arithmetic.
- A new command arriving after a HI byte drops that half pixel without output.

Optional Feature:
- Macro: ST7735_DEC_MADCTL_EN.
- When defined, pix_x/pix_y are remapped from madctl in this order:
  - MX (bit6) mirrors x: x = WIDTH-1-x.
  - MY (bit7) mirrors y: y = HEIGHT-1-y.
  - MV (bit5) then swaps x and y.
  - The remap adds one register stage, so pix_valid occurs 2 cycles after LO byte_stb.
- When undefined, raw cursor values are output and madctl is only stored.

Decomposition:
- Package st7735_pkg holds:
  - Opcode localparams: CMD_NOP, CMD_SWRESET, CMD_SLPIN, CMD_SLPOUT, CMD_NORON, CMD_DISPOFF, CMD_DISPON, CMD_CASET, CMD_RASET, CMD_RAMWR, CMD_MADCTL, CMD_COLMOD.
  - Default register values.
  - The decoder FSM state enum.
- Sub-module st7735_spi_rx holds the synchronizers, edge detect, shift register and bit counter; it outputs byte_stb, byte, is_data.

Test Plan:
- Send 0x11, 0x3A+0x05, 0x29 -> three cmd_valid pulses; sleep_out=1, colmod=0x05, disp_on=1; no cmd_err.
- CASET 00,02,00,03; RASET 00,05,00,06; RAMWR; then 5 pixels 0xF800,0x07E0,0x001F,0xFFFF,0x1234 -> pix (2,5),(3,5),(2,6),(3,6), then wrap to (2,5) with data 0x1234.
- RAMWR with default colmod 0x06 and 2 pixels -> no pix_valid. Then set COLMOD 0x05 and RAMWR again -> pix (0,0) is emitted.
- Opcode 0xB1 followed by 3 data bytes -> one cmd_err pulse, bytes ignored. A data byte sent after reset with no command -> cmd_err.
- Raise CS after 5 bits, then send a full 0x29 -> only 0x29 is decoded. Assert rst during the LO byte of a pixel -> no pix_valid, and all outputs return to their defaults.
- With ST7735_DEC_MADCTL_EN defined, MADCTL 0x40, RAMWR, 1 pixel -> pix_x=127, pix_y=0.
